// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//
// Packs RV32I instruction fields, presented one beat at a time over a
// valid/ready handshake, into 32-bit machine words and writes them to
// consecutive instruction-memory word addresses starting at BASE_ADDR.
//
// Parameters:
//   ADDR_W     instruction-memory word-address width (depth 2**ADDR_W)
//   BASE_ADDR  first word address written after start
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   start       one-cycle pulse opening a load session (ignored while loading)
//   in_valid    beat valid
//   in_ready    beat accepted on an edge with in_valid && in_ready
//   last        final beat of the program
//   op, funct3, funct7, rd, rs1, rs2, immSrc, imm   instruction fields
//   imem_we     one-cycle write strobe per encoded word
//   imem_addr   word address of the write
//   imem_wdata  encoded instruction word
//   busy        session in progress (LOAD)
//   done        session finished (DONE)
//   err         sticky error (overflow, or rejected beat when range checks
//               are enabled); cleared by the next start or reset
//
// Build option:
//   RANGE_CHECK_EN  when defined, beats whose immediate cannot be represented
//                   in their format are handshaken but not written, and set
//                   err. When undefined, immediates are truncated silently.
// ---------------------------------------------------------------------------
module instr_encoder #(
  parameter int          ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              last,
  input  logic [6:0]        op,
  input  logic [2:0]        funct3,
  input  logic              funct7,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [1:0]        immSrc,
  input  logic [31:0]       imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] BASE_W    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;

  localparam logic [1:0] FMT_I = 2'b00;
  localparam logic [1:0] FMT_S = 2'b01;
  localparam logic [1:0] FMT_B = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] addr_cnt_reg;

  logic        is_r;
  logic        is_shift;
  logic [31:0] word_next;
  logic        imm_ok;

  // R-type ignores immSrc entirely; the immediate shifts (slli/srli/srai)
  // carry funct7 in bit 30 and a 5-bit shamt instead of a 12-bit immediate.
  assign is_r     = (op == OP_R);
  assign is_shift = (op == OP_IMM) && ((funct3 == 3'b001) || (funct3 == 3'b101));

  // -------------------------------------------------------------------------
  // Field packing
  // -------------------------------------------------------------------------
  always_comb begin
    word_next = '0;
    if (is_r) begin
      word_next = {1'b0, funct7, 5'b00000, rs2, rs1, funct3, rd, op};
    end else if (is_shift) begin
      word_next = {1'b0, funct7, 5'b00000, imm[4:0], rs1, funct3, rd, op};
    end else begin
      case (immSrc)
        FMT_I:   word_next = {imm[11:0], rs1, funct3, rd, op};
        FMT_S:   word_next = {imm[11:5], rs2, rs1, funct3, imm[4:0], op};
        FMT_B:   word_next = {imm[12], imm[10:5], rs2, rs1, funct3,
                              imm[4:1], imm[11], op};
        default: word_next = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Immediate legality
  // -------------------------------------------------------------------------
`ifdef RANGE_CHECK_EN
  // A signed value fits in N bits exactly when every bit from N-1 upward is a
  // copy of the sign, i.e. the upper slice is all zeros or all ones.
  logic fits_12;
  logic fits_13;
  logic fits_21;

  assign fits_12 = (&imm[31:11]) | ~(|imm[31:11]);
  assign fits_13 = (&imm[31:12]) | ~(|imm[31:12]);
  assign fits_21 = (&imm[31:20]) | ~(|imm[31:20]);

  always_comb begin
    imm_ok = 1'b1;
    if (is_r) begin
      imm_ok = 1'b1;
    end else if (is_shift) begin
      imm_ok = ~(|imm[31:5]);
    end else begin
      case (immSrc)
        FMT_I, FMT_S: imm_ok = fits_12;
        FMT_B:        imm_ok = fits_13 & ~imm[0];
        default:      imm_ok = fits_21 & ~imm[0];
      endcase
    end
  end
`else
  // Without range checks the upper immediate bits are simply dropped.
  logic unused_imm_hi;

  assign unused_imm_hi = ^imm[31:21];
  assign imm_ok        = 1'b1;
`endif

  // Beats are only ever accepted in LOAD, so start arriving together with
  // in_valid in IDLE/DONE opens the session without consuming the beat.
  assign in_ready = (state_reg == LOAD);

  // -------------------------------------------------------------------------
  // Session FSM with registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      addr_cnt_reg <= BASE_W;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            state_reg    <= LOAD;
            addr_cnt_reg <= BASE_W;
            busy         <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
          end
        end

        LOAD: begin
          if (in_valid) begin
            if (imm_ok) begin
              imem_we    <= 1'b1;
              imem_addr  <= addr_cnt_reg;
              imem_wdata <= word_next;
              if (addr_cnt_reg == LAST_ADDR) begin
                // Memory is full: the session ends here, and it is an error
                // unless this happened to be the final beat anyway.
                state_reg <= DONE;
                busy      <= 1'b0;
                done      <= 1'b1;
                if (!last) begin
                  err <= 1'b1;
                end
              end else begin
                addr_cnt_reg <= addr_cnt_reg + ADDR_W'(1);
                if (last) begin
                  state_reg <= DONE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                end
              end
            end else begin
              // Rejected beat: handshaken, not written, address unchanged.
              err <= 1'b1;
              if (last) begin
                state_reg <= DONE;
                busy      <= 1'b0;
                done      <= 1'b1;
              end
            end
          end
        end

        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder
//
// Drives two instr_encoder instances (8-bit and 2-bit address space) from the
// same stimulus. A behavioural model tracks, per instance, the session phase
// and the number of words written, and a negedge process compares every
// output against it. Directed sessions pin the model with literal encodings.
// ---------------------------------------------------------------------------
module tb_instr_encoder;

  localparam int NI   = 2;
  localparam int AW_A = 8;
  localparam int AW_B = 2;
  localparam int unsigned BASE = 0;
  localparam int unsigned DEPTH [NI] = '{(1 << AW_A), (1 << AW_B)};

  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_DONE = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic        last;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [1:0]  imm_src;
  logic [31:0] imm;

  logic            ready_a, we_a, busy_a, done_a, err_a;
  logic [AW_A-1:0] addr_a;
  logic [31:0]     wdata_a;
  logic            ready_b, we_b, busy_b, done_b, err_b;
  logic [AW_B-1:0] addr_b;
  logic [31:0]     wdata_b;

  instr_encoder #(.ADDR_W(AW_A), .BASE_ADDR(BASE)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(ready_a), .last(last), .op(op), .funct3(funct3),
    .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2), .immSrc(imm_src),
    .imm(imm), .imem_we(we_a), .imem_addr(addr_a), .imem_wdata(wdata_a),
    .busy(busy_a), .done(done_a), .err(err_a)
  );

  instr_encoder #(.ADDR_W(AW_B), .BASE_ADDR(BASE)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(ready_b), .last(last), .op(op), .funct3(funct3),
    .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2), .immSrc(imm_src),
    .imm(imm), .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wdata_b),
    .busy(busy_b), .done(done_b), .err(err_b)
  );

  logic [31:0] d_ready [NI];
  logic [31:0] d_we    [NI];
  logic [31:0] d_addr  [NI];
  logic [31:0] d_wdata [NI];
  logic [31:0] d_busy  [NI];
  logic [31:0] d_done  [NI];
  logic [31:0] d_err   [NI];

  assign d_ready[0] = 32'(ready_a);
  assign d_we[0]    = 32'(we_a);
  assign d_addr[0]  = 32'(addr_a);
  assign d_wdata[0] = wdata_a;
  assign d_busy[0]  = 32'(busy_a);
  assign d_done[0]  = 32'(done_a);
  assign d_err[0]   = 32'(err_a);
  assign d_ready[1] = 32'(ready_b);
  assign d_we[1]    = 32'(we_b);
  assign d_addr[1]  = 32'(addr_b);
  assign d_wdata[1] = wdata_b;
  assign d_busy[1]  = 32'(busy_b);
  assign d_done[1]  = 32'(done_b);
  assign d_err[1]   = 32'(err_b);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) begin
        $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference: encoding from the field tables, using shifts and masks.
  // -------------------------------------------------------------------------
  function automatic logic [31:0] encode(input logic [6:0] o, input logic [2:0] f3,
                                         input logic f7, input logic [4:0] d,
                                         input logic [4:0] s1, input logic [4:0] s2,
                                         input logic [1:0] isrc, input logic [31:0] im);
    logic [31:0] mid;
    mid = (32'(s1) << 15) | (32'(f3) << 12) | 32'(o);
    if (o == 7'h33)
      return (32'(f7) << 30) | (32'(s2) << 20) | mid | (32'(d) << 7);
    if (o == 7'h13 && (f3 == 3'd1 || f3 == 3'd5))
      return (32'(f7) << 30) | ((im & 32'h1F) << 20) | mid | (32'(d) << 7);
    case (isrc)
      2'd0:    return ((im & 32'hFFF) << 20) | mid | (32'(d) << 7);
      2'd1:    return (((im >> 5) & 32'h7F) << 25) | (32'(s2) << 20) | mid
                      | ((im & 32'h1F) << 7);
      2'd2:    return (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25)
                      | (32'(s2) << 20) | mid | (((im >> 1) & 32'hF) << 8)
                      | (((im >> 11) & 32'h1) << 7);
      default: return (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                      | (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12)
                      | (32'(d) << 7) | 32'(o);
    endcase
  endfunction

`ifdef RANGE_CHECK_EN
  function automatic bit range_ok(input logic [6:0] o, input logic [2:0] f3,
                                  input logic [1:0] isrc, input logic [31:0] im);
    int s;
    s = int'(im);
    if (o == 7'h33) return 1'b1;
    if (o == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) return (im < 32);
    case (isrc)
      2'd0, 2'd1: return (s >= -2048 && s <= 2047);
      2'd2:       return (s >= -4096 && s <= 4094 && (s % 2 == 0));
      default:    return (s >= -(1 << 20) && s <= (1 << 20) - 2 && (s % 2 == 0));
    endcase
  endfunction
`endif

  // -------------------------------------------------------------------------
  // Behavioural model: session phase plus count of words written.
  // -------------------------------------------------------------------------
  int          m_mode  [NI];
  int unsigned n_wr    [NI];
  bit          m_we    [NI];
  int unsigned m_addr  [NI];
  logic [31:0] m_wdata [NI];
  bit          m_err   [NI];

  always @(posedge clk or negedge rst_n) begin
    bit ok;
    if (!rst_n) begin
      for (int i = 0; i < NI; i++) begin
        m_mode[i]  <= M_IDLE;
        n_wr[i]    <= 0;
        m_we[i]    <= 1'b0;
        m_addr[i]  <= 0;
        m_wdata[i] <= '0;
        m_err[i]   <= 1'b0;
      end
    end else begin
`ifdef RANGE_CHECK_EN
      ok = range_ok(op, funct3, imm_src, imm);
`else
      ok = 1'b1;
`endif
      for (int i = 0; i < NI; i++) begin
        m_we[i] <= 1'b0;
        if (m_mode[i] == M_LOAD) begin
          if (in_valid) begin
            if (ok) begin
              m_we[i]    <= 1'b1;
              m_addr[i]  <= BASE + n_wr[i];
              m_wdata[i] <= encode(op, funct3, funct7, rd, rs1, rs2, imm_src, imm);
              n_wr[i]    <= n_wr[i] + 1;
              if (last || (n_wr[i] + 1 == DEPTH[i])) m_mode[i] <= M_DONE;
              if (!last && (n_wr[i] + 1 == DEPTH[i])) m_err[i] <= 1'b1;
            end else begin
              m_err[i] <= 1'b1;
              if (last) m_mode[i] <= M_DONE;
            end
          end
        end else if (start) begin
          m_mode[i] <= M_LOAD;
          n_wr[i]   <= 0;
          m_err[i]  <= 1'b0;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Continuous comparison, away from the active edge.
  // -------------------------------------------------------------------------
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        chk($sformatf("rst_ready%0d", i), d_ready[i], 0);
        chk($sformatf("rst_we%0d", i),    d_we[i],    0);
        chk($sformatf("rst_addr%0d", i),  d_addr[i],  0);
        chk($sformatf("rst_wdata%0d", i), d_wdata[i], 0);
        chk($sformatf("rst_busy%0d", i),  d_busy[i],  0);
        chk($sformatf("rst_done%0d", i),  d_done[i],  0);
        chk($sformatf("rst_err%0d", i),   d_err[i],   0);
      end else begin
        chk($sformatf("ready%0d", i), d_ready[i], 32'(m_mode[i] == M_LOAD));
        chk($sformatf("busy%0d", i),  d_busy[i],  32'(m_mode[i] == M_LOAD));
        chk($sformatf("done%0d", i),  d_done[i],  32'(m_mode[i] == M_DONE));
        chk($sformatf("err%0d", i),   d_err[i],   32'(m_err[i]));
        chk($sformatf("we%0d", i),    d_we[i],    32'(m_we[i]));
        if (m_we[i]) begin
          chk($sformatf("addr%0d", i),  d_addr[i],  m_addr[i]);
          chk($sformatf("wdata%0d", i), d_wdata[i], m_wdata[i]);
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers: everything is driven at posedge+2; step() moves to the
  // next posedge+1 where directed checks are made, resume() returns to +2.
  // -------------------------------------------------------------------------
  task automatic drive(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [1:0] isrc, input logic [31:0] im, input logic l);
    op = o; funct3 = f3; funct7 = f7; rd = d; rs1 = s1; rs2 = s2;
    imm_src = isrc; imm = im; last = l; in_valid = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic resume();
    #1;
  endtask

  task automatic idle_beat();
    in_valid = 1'b0;
    last     = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    resume();
    start = 1'b0;
  endtask

  logic [6:0] op_tab [8];
  int         imm_tab [14];

  initial begin
    op_tab  = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37};
    imm_tab = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095, -4097,
                (1 << 20) - 2, (1 << 20), -(1 << 20), 3, 31, 32};

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; last = 1'b0;
    op = '0; funct3 = '0; funct7 = 1'b0; rd = '0; rs1 = '0; rs2 = '0;
    imm_src = '0; imm = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", d_ready[0], 0);
    chk("reset_we",    d_we[0],    0);
    chk("reset_addr",  d_addr[0],  0);
    chk("reset_wdata", d_wdata[0], 0);
    chk("reset_busy",  d_busy[0],  0);
    chk("reset_done",  d_done[0],  0);
    chk("reset_err",   d_err[0],   0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    // Session 1: start together with a valid beat; the beat waits a cycle.
    start = 1'b1;
    drive(7'h33, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 2'b00, 32'h0, 1'b0);
    step();
    chk("start_beat_not_taken", d_we[0], 0);
    chk("start_ready",          d_ready[0], 1);
    chk("start_busy",           d_busy[0], 1);
    resume();
    start = 1'b0;
    step();
    chk("add_we",    d_we[0],    1);
    chk("add_addr",  d_addr[0],  0);
    chk("add_wdata", d_wdata[0], 32'h002081B3);
    chk("add_model", m_wdata[0], 32'h002081B3);
    resume();
    funct7 = 1'b1;
    last   = 1'b1;
    step();
    chk("sub_addr",  d_addr[0],  1);
    chk("sub_wdata", d_wdata[0], 32'h402081B3);
    chk("sub_model", m_wdata[0], 32'h402081B3);
    chk("sub_done",  d_done[0],  1);
    resume();
    idle_beat();

    // Session 2: lw, sw, beq(last) back-to-back.
    pulse_start();
    drive(7'h03, 3'b010, 1'b0, 5'd5, 5'd2, 5'd0, 2'b00, 32'd8, 1'b0);
    step();
    chk("lw_addr",  d_addr[0],  0);
    chk("lw_wdata", d_wdata[0], 32'h00812283);
    chk("lw_model", m_wdata[0], 32'h00812283);
    resume();
    drive(7'h23, 3'b010, 1'b0, 5'd0, 5'd2, 5'd6, 2'b01, 32'hFFFFFFFC, 1'b0);
    step();
    chk("sw_we",    d_we[0],    1);
    chk("sw_addr",  d_addr[0],  1);
    chk("sw_wdata", d_wdata[0], 32'hFE612E23);
    chk("sw_model", m_wdata[0], 32'hFE612E23);
    resume();
    drive(7'h63, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 2'b10, 32'hFFFFFFF8, 1'b1);
    step();
    chk("beq_we",    d_we[0],    1);
    chk("beq_addr",  d_addr[0],  2);
    chk("beq_wdata", d_wdata[0], 32'hFE208CE3);
    chk("beq_model", m_wdata[0], 32'hFE208CE3);
    chk("beq_done",  d_done[0],  1);
    chk("beq_busy",  d_busy[0],  0);
    chk("beq_ready", d_ready[0], 0);
    resume();
    step();
    chk("after_done_ready", d_ready[0], 0);
    chk("after_done_we",    d_we[0],    0);
    resume();
    idle_beat();

    // Session 3: five beats without last overflow the 4-word instance.
    pulse_start();
    for (int k = 0; k < 5; k++) begin
      drive(7'h33, 3'($urandom), 1'($urandom), 5'($urandom), 5'($urandom),
            5'($urandom), 2'($urandom), $urandom, 1'b0);
      step();
      chk("ovf_small_we", d_we[1], 32'(k < 4));
      if (k < 4) chk("ovf_small_addr", d_addr[1], k);
      chk("ovf_big_addr", d_addr[0], k);
      if (k >= 3) begin
        chk("ovf_small_err",   d_err[1],   1);
        chk("ovf_small_done",  d_done[1],  1);
        chk("ovf_small_ready", d_ready[1], 0);
      end
      resume();
    end
    idle_beat();
    pulse_start();
    chk("restart_small_err",  d_err[1],  0);
    chk("restart_small_busy", d_busy[1], 1);
    drive(7'h33, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 2'b00, 32'h0, 1'b1);
    step();
    chk("restart_small_addr", d_addr[1], 0);
    chk("ignored_start_big_addr", d_addr[0], 5);
    resume();
    idle_beat();

    // Session 4: B-format immediate 3 (odd).
    pulse_start();
    drive(7'h63, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 2'b10, 32'd3, 1'b0);
    step();
`ifdef RANGE_CHECK_EN
    chk("bad_b_we",    d_we[0],    0);
    chk("bad_b_err",   d_err[0],   1);
    chk("bad_b_ready", d_ready[0], 1);
`else
    chk("trunc_b_we",    d_we[0],    1);
    chk("trunc_b_wdata", d_wdata[0], 32'h00208163);
    chk("trunc_b_err",   d_err[0],   0);
`endif
    resume();
    drive(7'h03, 3'b010, 1'b0, 5'd5, 5'd2, 5'd0, 2'b00, 32'd8, 1'b1);
    step();
`ifdef RANGE_CHECK_EN
    chk("after_bad_addr", d_addr[0], 0);
`else
    chk("after_trunc_addr", d_addr[0], 1);
`endif
    chk("after_b_wdata", d_wdata[0], 32'h00812283);
    resume();
    idle_beat();

    // Session 5: reset in the middle of a session.
    pulse_start();
    drive(7'h33, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 2'b00, 32'h0, 1'b0);
    step();
    resume();
    step();
    chk("pre_rst_we", d_we[0], 1);
    resume();
    rst_n = 1'b0;
    #1;
    chk("midrst_we",    d_we[0],    0);
    chk("midrst_addr",  d_addr[0],  0);
    chk("midrst_wdata", d_wdata[0], 0);
    chk("midrst_busy",  d_busy[0],  0);
    chk("midrst_ready", d_ready[0], 0);
    idle_beat();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    pulse_start();
    drive(7'h33, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 2'b00, 32'h0, 1'b1);
    step();
    chk("post_rst_addr", d_addr[0], BASE);
    chk("post_rst_we",   d_we[0],   1);
    resume();
    idle_beat();

    // Randomised traffic, checked by the negedge compare process.
    for (int c = 0; c < 3000; c++) begin
      int sel;
      rst_n    = ($urandom_range(0, 399) != 0);
      start    = ($urandom_range(0, 15) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      last     = ($urandom_range(0, 11) == 0);
      op       = ($urandom_range(0, 4) == 0) ? 7'($urandom) : op_tab[$urandom_range(0, 7)];
      funct3   = 3'($urandom);
      funct7   = 1'($urandom);
      rd       = 5'($urandom);
      rs1      = 5'($urandom);
      rs2      = 5'($urandom);
      imm_src  = 2'($urandom);
      sel      = $urandom_range(0, 5);
      case (sel)
        0:       imm = 32'($signed($urandom_range(0, 63)) - 32);
        1:       imm = 32'(imm_tab[$urandom_range(0, 13)]);
        2:       imm = $urandom;
        3:       imm = 32'($signed($urandom_range(0, 4095)) - 2048);
        4:       imm = 32'($signed($urandom_range(0, 8191)) - 4096);
        default: imm = 32'($signed($urandom_range(0, 32'h3FFFFF)) - 32'h200000);
      endcase
      @(posedge clk);
      #2;
    end
    rst_n = 1'b1;
    start = 1'b0;
    idle_beat();
    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
